store_buffer: RTL
=================

# store_buffer

Parametrised write-side store buffer between the execute stage and the data-memory port. Converts RISC-V SB/SH/SW(/SD) requests into lane-aligned data plus byte-write mask, and queues them in a DEPTH-entry FIFO so memory back-pressure does not stall the pipeline. Misaligned or unsupported stores are detected and dropped with an error pulse. Optionally merges consecutive stores that target the same word.

## Interface
- XLEN, 32: data width; 32 or 64 only.
- DEPTH, 4: FIFO entries; power of two, ≥2.
- ADDR_W, 32: byte-address width.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  store request valid.
- in_ready  out  1  buffer can accept; equals !full.
- in_funct3  in  3  store funct3: 000 SB, 001 SH, 010 SW, 011 SD (XLEN=64 only).
- in_addr  in  ADDR_W  byte address.
- in_data  in  XLEN  register data; low bytes are stored.
- out_valid  out  1  head entry valid.
- out_ready  in  1  memory accepts head entry.
- out_addr  out  ADDR_W  word-aligned address; low log2(XLEN/8) bits are 0.
- out_data  out  XLEN  lane-shifted data; unmasked lanes are 0.
- out_mask  out  XLEN/8  byte-write enables.
- count  out  log2(DEPTH)+1  occupied entries.
- err_misalign  out  1  one-cycle pulse for a dropped store.

## Operation
- Accept when in_valid && in_ready. Lane offset off = in_addr[log2(XLEN/8)-1:0].
- SB: mask = 1<<off; data byte 0 placed at lane off.
- SH: requires off[0]=0; mask = 2'b11<<off; low halfword placed at lanes off, off+1.
- SW: requires off[1:0]=0; mask = 4'hF<<off.
- SD: XLEN=64 and off=0; mask = 8'hFF.
- Misaligned, or funct3 not listed for this XLEN: handshake still completes; nothing enqueued; err_misalign=1 in the following cycle.
- Entry is written at tail, popped at head on out_valid && out_ready. Pointers wrap modulo DEPTH.
- Simultaneous push and pop: count unchanged; both take effect.
- Full: in_ready=0; a pop in the same cycle does not open a slot until the next cycle (no pass-through).
- Empty: out_valid=0; out_addr/out_data/out_mask hold their last values and are don't-care.
- The out_* signals are driven directly from head-entry registers.

## Timing
- Reset: count=0, out_valid=0, err_misalign=0, out_addr/out_data/out_mask=0, pointers=0. Assertion mid-operation discards all entries immediately (asynchronous).
- Latency: a store accepted at edge N is visible on out_valid after edge N (cycle N+1) when the buffer was empty.
- Sustained throughput: 1 store/cycle in and 1 store/cycle out when not full.
- out_* are stable while out_valid && !out_ready.
- err_misalign is high for exactly one cycle per dropped store.

## Configuration
- STORE_MERGE_EN defined: an accepted store whose word address equals the tail entry's address merges into that entry instead of allocating a new one.
  - Merged mask = old | new; lanes set in the new mask take the new data.
  - count does not change.
  - No merge when the tail is also the head and is being popped in the same cycle; the store then allocates a new entry.
  - in_ready remains !full, so a merge is never offered when full.
- STORE_MERGE_EN undefined: every accepted valid store allocates an entry.

## Structure
- Put the funct3 constants (FNC_SB/SH/SW/SD) and the STORE_MERGE_EN guard in the shared opcode header/package.
- Sub-module store_align (combinational): funct3, offset, data in; shifted data, mask and misalign flag out. Instantiated once.
- store_buffer holds the FIFO storage, pointers, count, merge logic and error register.

## Test plan
1. XLEN=32, SB data 0x12345678 @0x1001, out_ready=1 → next cycle out_addr=0x1000, out_data=0x00007800, out_mask=0010.
2. SH 0x12345678 @0x2002 → out_data=0x56780000, mask=1100. SH @0x2003 → no entry, err_misalign pulses once, count stays 0.
3. out_ready=0, push 4 SW → count=4, in_ready=0, a 5th store is not accepted. Then raise out_ready → entries drain in order, one per cycle.
4. Buffer full with a simultaneous push attempt and pop → pop occurs, push is refused, count=3. Empty buffer with simultaneous push and pop → push lands, out_valid next cycle.
5. STORE_MERGE_EN, out_ready=0: SB 0xAA @0x10, then SB 0xBB @0x13 → count=1, out_data=0xBB0000AA, mask=1001. Without the macro → count=2.
6. Deassert rst_n with 3 entries queued → count=0 and out_valid=0 at once. XLEN=64: SD 0x0123456789ABCDEF @0x8 → mask=0xFF.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: shared store-opcode constants and feature switch for the
// store buffer.
//
// Contents:
//   FNC_SB/FNC_SH/FNC_SW/FNC_SD : RISC-V store funct3 encodings.
//   MERGE_EN                    : 1 when STORE_MERGE_EN is defined, else 0.
//
// Build macro: STORE_MERGE_EN. When it is defined, an accepted store that hits
// the tail entry's word is merged into that entry instead of allocating one.
package store_buffer_pkg;

    localparam logic [2:0] FNC_SB = 3'b000;
    localparam logic [2:0] FNC_SH = 3'b001;
    localparam logic [2:0] FNC_SW = 3'b010;
    localparam logic [2:0] FNC_SD = 3'b011;

`ifdef STORE_MERGE_EN
    localparam bit MERGE_EN = 1'b1;
`else
    localparam bit MERGE_EN = 1'b0;
`endif

endpackage

// File: rtl/store_align.sv
// store_align: combinational store-lane formatter.
//
// Ports:
//   funct3    in   store size encoding (SB/SH/SW/SD)
//   off       in   byte offset of the address inside the data word
//   data      in   register data; low bytes are stored
//   lane_data out  data shifted to its byte lanes, other lanes zero
//   lane_mask out  byte-write enables
//   misalign  out  store is misaligned or funct3 is illegal for XLEN
module store_align
    import store_buffer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]                  funct3,
    input  logic [$clog2(XLEN/8)-1:0]   off,
    input  logic [XLEN-1:0]             data,
    output logic [XLEN-1:0]             lane_data,
    output logic [XLEN/8-1:0]           lane_mask,
    output logic                        misalign
);

    logic [XLEN-1:0]   base_data;
    logic [XLEN/8-1:0] base_mask;

    always_comb begin
        base_data = '0;
        base_mask = '0;
        misalign  = 1'b0;
        case (funct3)
            FNC_SB: begin
                base_data[7:0] = data[7:0];
                base_mask[0]   = 1'b1;
            end
            FNC_SH: begin
                base_data[15:0] = data[15:0];
                base_mask[1:0]  = 2'b11;
                misalign        = off[0];
            end
            FNC_SW: begin
                base_data[31:0] = data[31:0];
                base_mask[3:0]  = 4'hF;
                misalign        = |off[1:0];
            end
            FNC_SD: begin
                // Doubleword stores only exist on the 64-bit datapath.
                if (XLEN == 64) begin
                    base_data = data;
                    base_mask = '1;
                    misalign  = |off;
                end else begin
                    misalign = 1'b1;
                end
            end
            default: misalign = 1'b1;
        endcase
        lane_data = base_data << {off, 3'b000};
        lane_mask = base_mask << off;
    end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: write-side store buffer between execute and the data-memory
// port. Formats SB/SH/SW(/SD) into lane data plus byte mask and queues them in
// a DEPTH-entry FIFO. Misaligned/illegal stores are dropped with a one-cycle
// err_misalign pulse.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          request handshake (in_ready = !full)
//   in_funct3/in_addr/in_data  store request
//   out_valid/out_ready        head-entry handshake to memory
//   out_addr/out_data/out_mask head entry (word-aligned address)
//   count                      occupied entries
//   err_misalign               pulse one cycle after a dropped store
//
// Build macro: STORE_MERGE_EN (via store_buffer_pkg::MERGE_EN) enables merging
// a store into the tail entry when it targets the same word.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                in_funct3,
    input  logic [ADDR_W-1:0]         in_addr,
    input  logic [XLEN-1:0]           in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ADDR_W-1:0]         out_addr,
    output logic [XLEN-1:0]           out_data,
    output logic [XLEN/8-1:0]         out_mask,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      err_misalign
);

    localparam int MW    = XLEN / 8;
    localparam int OFF_W = $clog2(MW);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [XLEN-1:0]   data_q [DEPTH];
    logic [MW-1:0]     mask_q [DEPTH];
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;
    logic              err_q;

    logic [XLEN-1:0]   lane_data;
    logic [MW-1:0]     lane_mask;
    logic              misalign;
    logic [ADDR_W-1:0] word_addr;
    logic [PTR_W-1:0]  last_ptr;
    logic              full;
    logic              empty;
    logic              push_fire;
    logic              pop_fire;
    logic              store_ok;
    logic              merge_hit;
    logic              alloc;
    logic [XLEN-1:0]   merge_data;

    store_align #(
        .XLEN (XLEN)
    ) u_align (
        .funct3    (in_funct3),
        .off       (in_addr[OFF_W-1:0]),
        .data      (in_data),
        .lane_data (lane_data),
        .lane_mask (lane_mask),
        .misalign  (misalign)
    );

    assign word_addr = {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign last_ptr  = tail_q - 1'b1;
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign push_fire = in_valid && !full;
    assign pop_fire  = !empty && out_ready;
    assign store_ok  = push_fire && !misalign;

    // A lone entry that is leaving this cycle cannot absorb the store; the
    // store then takes a fresh slot instead.
    assign merge_hit = MERGE_EN && store_ok && !empty
                       && (addr_q[last_ptr] == word_addr)
                       && !((count_q == CNT_W'(1)) && pop_fire);
    assign alloc     = store_ok && !merge_hit;

    always_comb begin
        merge_data = data_q[last_ptr];
        for (int i = 0; i < MW; i++) begin
            if (lane_mask[i]) begin
                merge_data[i*8 +: 8] = lane_data[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                mask_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= push_fire && misalign;
            if (alloc) begin
                addr_q[tail_q] <= word_addr;
                data_q[tail_q] <= lane_data;
                mask_q[tail_q] <= lane_mask;
                tail_q         <= tail_q + 1'b1;
            end else if (merge_hit) begin
                data_q[last_ptr] <= merge_data;
                mask_q[last_ptr] <= mask_q[last_ptr] | lane_mask;
            end
            if (pop_fire) begin
                head_q <= head_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(alloc) - CNT_W'(pop_fire);
        end
    end

    assign in_ready     = !full;
    assign out_valid    = !empty;
    assign out_addr     = addr_q[head_q];
    assign out_data     = data_q[head_q];
    assign out_mask     = mask_q[head_q];
    assign count        = count_q;
    assign err_misalign = err_q;

endmodule
